// File: rtl/rsa_operand_loader.sv
// Buffers one RSA operand set (modulus n, ciphertext m, exponent e) for the MonPro stage.
// Define LOADER_EXP_SCAN_EN to track the exponent's highest set bit while loading.
module rsa_operand_loader #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_load,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   n_in,
    input  logic [DATA_WIDTH-1:0]   m_in,
    input  logic [DATA_WIDTH-1:0]   e_in,
    output logic                    operands_ready,
    input  logic                    release_req,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   n_out,
    output logic [DATA_WIDTH-1:0]   m_out,
    output logic [DATA_WIDTH-1:0]   e_out,
    output logic                    n_err,
    output logic [ADDR_WIDTH+5:0]   e_msb_idx,
    output logic                    e_zero
);

    typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic                    n_err_q, n_err_d;
    logic [DATA_WIDTH-1:0]   n_out_q, n_out_d;
    logic [DATA_WIDTH-1:0]   m_out_q, m_out_d;
    logic [DATA_WIDTH-1:0]   e_out_q, e_out_d;
    logic                    wr_en;

    logic [DATA_WIDTH-1:0]   n_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0]   m_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0]   e_mem [2**ADDR_WIDTH];

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        n_err_d        = n_err_q;
        wr_en          = 1'b0;
        in_ready       = 1'b0;
        operands_ready = 1'b0;
        case (state_q)
            IDLE: ;
            LOAD: begin
                in_ready = 1'b1;
                if (!start_load && in_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                    if (wr_ptr_q == '0)
                        n_err_d = ~n_in[0];
                    if (wr_ptr_q == '1)
                        state_d = FULL;
                end
            end
            FULL: begin
                operands_ready = 1'b1;
                if (release_req)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A restart overrides any write or release seen in the same cycle.
        if (start_load) begin
            state_d  = LOAD;
            wr_ptr_d = '0;
            n_err_d  = 1'b0;
        end
    end

    always_comb begin
        n_out_d = n_out_q;
        m_out_d = m_out_q;
        e_out_d = e_out_q;
        if (rd_en) begin
            n_out_d = n_mem[rd_addr];
            m_out_d = m_mem[rd_addr];
            e_out_d = e_mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            n_err_q  <= 1'b0;
            n_out_q  <= '0;
            m_out_q  <= '0;
            e_out_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            n_err_q  <= n_err_d;
            n_out_q  <= n_out_d;
            m_out_q  <= m_out_d;
            e_out_q  <= e_out_d;
        end
    end

    // Storage is deliberately unreset; the read path samples it before this edge's write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            n_mem[wr_ptr_q] <= n_in;
            m_mem[wr_ptr_q] <= m_in;
            e_mem[wr_ptr_q] <= e_in;
        end
    end

    assign n_out = n_out_q;
    assign m_out = m_out_q;
    assign e_out = e_out_q;
    assign n_err = n_err_q;

`ifdef LOADER_EXP_SCAN_EN
    logic [ADDR_WIDTH+5:0] e_msb_idx_q, e_msb_idx_d;
    logic                  e_zero_q, e_zero_d;

    function automatic logic [5:0] msb_pos(input logic [DATA_WIDTH-1:0] v);
        logic [5:0] pos;
        pos = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            if (v[i])
                pos = 6'(i);
        return pos;
    endfunction

    // Words arrive LSW first, so the last nonzero word seen holds the global MSB.
    always_comb begin
        e_msb_idx_d = e_msb_idx_q;
        e_zero_d    = e_zero_q;
        if (start_load) begin
            e_msb_idx_d = '0;
            e_zero_d    = 1'b1;
        end else if (wr_en && (e_in != '0)) begin
            e_msb_idx_d = {wr_ptr_q, msb_pos(e_in)};
            e_zero_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_msb_idx_q <= '0;
            e_zero_q    <= 1'b1;
        end else begin
            e_msb_idx_q <= e_msb_idx_d;
            e_zero_q    <= e_zero_d;
        end
    end

    assign e_msb_idx = e_msb_idx_q;
    assign e_zero    = e_zero_q;
`else
    assign e_msb_idx = '1;
    assign e_zero    = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Self-checking bench for rsa_operand_loader: directed table, hand sequences and
// randomized traffic compared against a word-level reference model.
module tb_rsa_operand_loader;

    localparam int NW = 64;
`ifdef LOADER_EXP_SCAN_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_load = 1'b0, in_valid = 1'b0, release_req = 1'b0, rd_en = 1'b0;
    logic [5:0]  rd_addr = '0;
    logic [63:0] n_in = '0, m_in = '0, e_in = '0;
    logic        in_ready, operands_ready, n_err, e_zero;
    logic [63:0] n_out, m_out, e_out;
    logic [11:0] e_msb_idx;

    always #5 clk = ~clk;

    rsa_operand_loader #(.DATA_WIDTH(64), .ADDR_WIDTH(6)) dut (
        .clk(clk), .reset(reset), .start_load(start_load), .in_valid(in_valid),
        .in_ready(in_ready), .n_in(n_in), .m_in(m_in), .e_in(e_in),
        .operands_ready(operands_ready), .release_req(release_req),
        .rd_en(rd_en), .rd_addr(rd_addr), .n_out(n_out), .m_out(m_out), .e_out(e_out),
        .n_err(n_err), .e_msb_idx(e_msb_idx), .e_zero(e_zero)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: operand store plus load progress in words
    logic [63:0] rn [NW], rm [NW], re [NW];
    bit          known [NW];
    bit          loading, full, x_nerr, x_ezero, x_known;
    int          cnt, x_msb;
    logic [63:0] x_n, x_m, x_e;

    typedef struct {
        bit st; bit vl; bit rl; int reps; bit x_rdy; bit x_opr;
    } vec_t;
    vec_t tbl [14];

    function automatic int top_bit(input logic [63:0] v);
        int r = -1;
        for (int i = 0; i < 64; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        loading = 0; full = 0; cnt = 0; x_nerr = 0;
        x_msb   = SCAN ? 0 : 4095;
        x_ezero = SCAN;
        x_n = '0; x_m = '0; x_e = '0; x_known = 1;
    endtask

    task automatic check_all();
        chk("in_ready", 64'(in_ready), 64'(loading));
        chk("operands_ready", 64'(operands_ready), 64'(full));
        chk("n_err", 64'(n_err), 64'(x_nerr));
        chk("e_msb_idx", 64'(e_msb_idx), 64'(x_msb));
        chk("e_zero", 64'(e_zero), 64'(x_ezero));
        if (x_known) begin
            chk("n_out", n_out, x_n);
            chk("m_out", m_out, x_m);
            chk("e_out", e_out, x_e);
        end
    endtask

    task automatic cyc(input bit st, input bit vl, input bit rl, input bit rde, input int ra,
                       input logic [63:0] n, input logic [63:0] m, input logic [63:0] e);
        start_load = st; in_valid = vl; release_req = rl; rd_en = rde;
        rd_addr = 6'(ra); n_in = n; m_in = m; e_in = e;
        @(posedge clk);
        if (rde) begin
            x_known = known[ra]; x_n = rn[ra]; x_m = rm[ra]; x_e = re[ra];
        end
        if (st) begin
            loading = 1; full = 0; cnt = 0; x_nerr = 0;
            if (SCAN) begin x_msb = 0; x_ezero = 1; end
        end else if (loading && vl) begin
            rn[cnt] = n; rm[cnt] = m; re[cnt] = e; known[cnt] = 1;
            if (cnt == 0) x_nerr = !n[0];
            if (SCAN && e != 0) begin x_msb = cnt * 64 + top_bit(e); x_ezero = 0; end
            cnt++;
            if (cnt == NW) begin loading = 0; full = 1; cnt = 0; end
        end else if (full && rl) begin
            full = 0;
        end
        #1;
        check_all();
    endtask

    task automatic word(input logic [63:0] n, input logic [63:0] m, input logic [63:0] e);
        cyc(0, 1, 0, 0, 0, n, m, e);
    endtask

    task automatic idle_cyc(input bit st, input bit rl);
        cyc(st, 0, rl, 0, 0, '0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < NW; i++) known[i] = 0;
        model_reset();
        tbl[0]  = '{1, 0, 0, 1,  1, 0};
        tbl[1]  = '{0, 1, 0, 63, 1, 0};
        tbl[2]  = '{0, 1, 0, 1,  0, 1};
        tbl[3]  = '{0, 1, 0, 3,  0, 1};
        tbl[4]  = '{0, 0, 1, 1,  0, 0};
        tbl[5]  = '{0, 1, 0, 2,  0, 0};
        tbl[6]  = '{1, 0, 0, 1,  1, 0};
        tbl[7]  = '{0, 1, 0, 10, 1, 0};
        tbl[8]  = '{0, 0, 0, 5,  1, 0};
        tbl[9]  = '{0, 1, 0, 54, 0, 1};
        tbl[10] = '{1, 0, 1, 1,  1, 0};
        tbl[11] = '{0, 1, 0, 20, 1, 0};
        tbl[12] = '{1, 1, 0, 1,  1, 0};
        tbl[13] = '{0, 1, 0, 64, 0, 1};

        // Reset state
        #12;
        check_all();
        @(posedge clk); #1;
        reset = 0;

        // Known vector load, then read word 0
        idle_cyc(1, 0);
        word(64'hE29A87C176A78B35, 64'h384CB8DCF02466CE, 64'h1A32639C11288001);
        for (int k = 1; k < 63; k++) word(r64(), r64(), r64());
        chk("opr_before_last", 64'(operands_ready), 64'd0);
        word(r64(), r64(), r64());
        chk("opr_after_last", 64'(operands_ready), 64'd1);
        cyc(0, 0, 0, 1, 0, '0, '0, '0);
        chk("rd0_n", n_out, 64'hE29A87C176A78B35);
        chk("rd0_m", m_out, 64'h384CB8DCF02466CE);
        chk("rd0_e", e_out, 64'h1A32639C11288001);
        chk("n_err_odd", 64'(n_err), 64'd0);
        idle_cyc(0, 1);
        chk("released", 64'(operands_ready), 64'd0);

        // Directed table
        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++)
                cyc(tbl[i].st, tbl[i].vl, tbl[i].rl, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 63), r64(), r64(), r64());
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].x_rdy));
            chk($sformatf("tbl%0d_opr", i), 64'(operands_ready), 64'(tbl[i].x_opr));
        end
        idle_cyc(0, 1);

        // Exponent scan: single bit in word 5, then all-zero exponent
        idle_cyc(1, 0);
        for (int k = 0; k < NW; k++) word(r64(), r64(), (k == 5) ? 64'h100 : 64'h0);
        chk("scan_msb_328", 64'(e_msb_idx), SCAN ? 64'd328 : 64'd4095);
        chk("scan_nonzero", 64'(e_zero), 64'd0);
        idle_cyc(1, 0);
        for (int k = 0; k < NW; k++) word(r64(), r64(), 64'h0);
        chk("scan_all_zero", 64'(e_zero), SCAN ? 64'd1 : 64'd0);
        chk("scan_zero_msb", 64'(e_msb_idx), SCAN ? 64'd0 : 64'd4095);

        // Even modulus flags n_err, held through FULL
        idle_cyc(1, 0);
        word(64'h6A9B8743E2AC3B9E, r64(), r64());
        chk("n_err_even", 64'(n_err), 64'd1);
        for (int k = 1; k < NW; k++) word(r64() | 64'h1, r64(), r64());
        idle_cyc(0, 0);
        chk("n_err_full", 64'(n_err), 64'd1);
        chk("n_err_full_opr", 64'(operands_ready), 64'd1);

        // Reset mid-load abandons the partial load
        idle_cyc(1, 0);
        for (int k = 0; k < 20; k++) word(r64(), r64(), r64());
        reset = 1;
        #2;
        model_reset();
        check_all();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        reset = 0;
        word(r64(), r64(), r64());
        chk("post_rst_ignored", 64'(in_ready), 64'd0);
        idle_cyc(1, 0);
        for (int k = 0; k < NW; k++) word(r64(), r64(), r64());
        chk("post_rst_full", 64'(operands_ready), 64'd1);

        // Randomized traffic
        for (int c = 0; c < 2500; c++)
            cyc(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) < 7),
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                $urandom_range(0, 63), r64(), r64(), r64());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rsa_operand_loader.md
RSA_OPERAND_LOADER -- requirements
Module: rsa_operand_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, word width of each operand slice.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, so one operand is 2**ADDR_WIDTH words (64 words = 4096 bits).
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  async active-high reset.
REQ-004 SHALL have start_load  input  1  begins or restarts a load; this is a single-cycle strobe.
REQ-005 SHALL have in_valid  input  1  word triple present on n_in/m_in/e_in.
REQ-006 SHALL have in_ready  output  1  loader accepts a word this cycle.
REQ-007 SHALL have n_in, m_in, e_in  input  DATA_WIDTH each  modulus, ciphertext and private-exponent slices, least significant word first.
REQ-008 SHALL have operands_ready  output  1  all words stored, asserted as a level to the MonPro stage.
REQ-009 SHALL have release  input  1  MonPro has finished with the operands.
REQ-010 SHALL have rd_en  input  1  and  rd_addr  input  ADDR_WIDTH  word read request from MonPro.
REQ-011 SHALL have n_out, m_out, e_out  output  DATA_WIDTH each  registered read data.
REQ-012 SHALL have n_err  output  1  modulus is even, so it is unusable for Montgomery multiplication.
REQ-013 SHALL have e_msb_idx  output  ADDR_WIDTH+6  bit index of the highest set bit of e, and e_zero  output  1  e is all zero.

Function
REQ-014 SHALL implement states IDLE, LOAD and FULL in a registered FSM.
REQ-015 IDLE: in_ready=0; start_load moves to LOAD.
REQ-016 LOAD: in_ready=1; each cycle with in_valid=1 writes the triple at wr_ptr into three 2**ADDR_WIDTH x DATA_WIDTH arrays and increments wr_ptr.
REQ-017 When the write at wr_ptr=2**ADDR_WIDTH-1 is accepted, wr_ptr SHALL wrap to 0, the FSM SHALL enter FULL next cycle, and operands_ready SHALL rise in that same cycle.
REQ-018 In LOAD, in_valid=0 SHALL stall without changing wr_ptr, for any number of cycles.
REQ-019 FULL: in_ready=0; operands_ready=1; release returns the FSM to IDLE and clears operands_ready on the next edge.
REQ-020 start_load in any state, including mid-LOAD, SHALL enter or re-enter LOAD with wr_ptr=0, operands_ready=0 and n_err/e flags cleared. start_load wins over a simultaneous in_valid write and over a simultaneous release.
REQ-021 Reads SHALL be legal in any state: when rd_en=1 in cycle t, the outputs SHALL present the array contents at rd_addr in cycle t+1; when rd_en=0 the outputs SHALL hold.
REQ-022 A read and a write to the same address in the same cycle SHALL return the old data (read-before-write).
REQ-023 n_err SHALL be set when word 0 is accepted with n_in[0]=0, and SHALL be cleared when word 0 is accepted with n_in[0]=1.
REQ-024 Array contents are not reset; reads before the first load return undefined data.

Reset
REQ-025 On reset: state=IDLE, wr_ptr=0, in_ready=0, operands_ready=0, n_out=m_out=e_out=0, n_err=0, e_msb_idx=0, e_zero=1.
REQ-026 A reset asserted mid-LOAD SHALL abandon the partial load; a new start_load is then required.

Configuration
REQ-027 Macro LOADER_EXP_SCAN_EN SHALL control exponent scanning.
REQ-028 With LOADER_EXP_SCAN_EN defined: for each accepted word k with e_in!=0, e_msb_idx <= {k, priority-encoded index of the highest set bit of e_in} and e_zero <= 0. Because higher words arrive later, the final value is the global MSB, and it SHALL be stable whenever operands_ready=1.
REQ-029 Without LOADER_EXP_SCAN_EN: no scan logic SHALL be present, e_msb_idx SHALL be constant 2**(ADDR_WIDTH+6)-1 (4095), and e_zero SHALL be constant 0.

Verification
REQ-030 Reset, then start_load, then 64 consecutive valid words with word 0 n=64'hE29A87C176A78B35, m=64'h384CB8DCF02466CE, e=64'h1A32639C11288001 -> operands_ready=1 exactly one cycle after the 64th accepted word; reading rd_addr=0 returns those three values one cycle later; n_err=0.
REQ-031 Same load with in_valid deasserted for 5 cycles after word 10 -> wr_ptr holds at 11; operands_ready rises only after all 64 words are accepted.
REQ-032 start_load asserted after 20 words -> next accepted word lands at address 0; operands_ready rises only after 64 further words.
REQ-033 FULL, then release=1 -> IDLE and operands_ready=0 next cycle; in_valid is ignored while in IDLE.
REQ-034 LOADER_EXP_SCAN_EN defined, e words all 0 except word 5=64'h0000000000000100 -> e_msb_idx=328, e_zero=0. All e words 0 -> e_zero=1. Macro undefined -> e_msb_idx=4095.
REQ-035 Word 0 n=64'h6A9B8743E2AC3B9E (even) -> n_err=1 after word 0 is accepted, and it stays 1 through FULL.
